stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/bcd60_counter.sv | 54 +++++
 rtl/stopwatch_ctrl.sv | 149 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss stopwatch: FSM state encoding and default tick rate.
package stopwatch_pkg;

  localparam int STATE_W          = 2;
  localparam int TICK_DIV_DEFAULT = 100_000_000;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    STOP     = 2'd1,
    COUNTING = 2'd2,
    LAP      = 2'd3
  } sw_state_e;

endpackage

// File: rtl/bcd60_counter.sv
// Two-digit BCD modulo-60 counter; carry is high on the enabled 59 -> 00 wrap.
module bcd60_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  // Digit wrap uses >= so a corrupted digit recovers on its next increment.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    carry  = 1'b0;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (en) begin
      if (ones_q >= 4'd9) begin
        ones_d = 4'd0;
        if (tens_q >= 4'd5) begin
          tens_d = 4'd0;
          carry  = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
      tens_d = tens_q;
      ones_d = ones_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detect, run/stop/lap FSM, tick divider,
// lap snapshot and registered BCD mm:ss display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic [1:0] state,
  output logic       running,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       overflow
);

  localparam int                DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(TICK_DIV - 1);

  sw_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             btn_start_q, btn_lap_q;
  logic [15:0]      snap_q, snap_d;
  logic [15:0]      disp_q, disp_d;
  logic             overflow_q;

  logic             start_pls_s, lap_pls_s, tick_s, time_clr_s;
  logic             sec_carry_s, min_carry_s;
  logic [3:0]       sec_tens_s, sec_ones_s, min_tens_s, min_ones_s;
  logic [15:0]      live_s;

  // Start has priority, so a simultaneous lap press is dropped here.
  assign start_pls_s = btn_start & ~btn_start_q;
  assign lap_pls_s   = btn_lap & ~btn_lap_q & ~start_pls_s;
  assign running     = (state_q == COUNTING) || (state_q == LAP);
  assign time_clr_s  = (state_q == STOP) && lap_pls_s;
  assign live_s      = {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_pls_s) state_d = COUNTING;
        else             state_d = IDLE;
      end
      COUNTING: begin
        if (start_pls_s)    state_d = STOP;
        else if (lap_pls_s) state_d = LAP;
        else                state_d = COUNTING;
      end
      LAP: begin
        if (start_pls_s)    state_d = STOP;
        else if (lap_pls_s) state_d = COUNTING;
        else                state_d = LAP;
      end
      STOP: begin
        if (start_pls_s)    state_d = COUNTING;
        else if (lap_pls_s) state_d = IDLE;
        else                state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d  = div_q;
    tick_s = 1'b0;
    if (time_clr_s) begin
      div_d = {DIV_W{1'b0}};
    end else if (running) begin
      if (div_q == DIV_MAX) begin
        tick_s = 1'b1;
        div_d  = {DIV_W{1'b0}};
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else if (state_q == IDLE) begin
      div_d = {DIV_W{1'b0}};
    end else begin
      div_d = div_q;
    end
  end

  // Snapshot takes the pre-edge live time; the display lags the state by one cycle.
  always_comb begin
    snap_d = snap_q;
    if (time_clr_s) begin
      snap_d = 16'd0;
    end else if ((state_q == COUNTING) && lap_pls_s) begin
      snap_d = live_s;
    end else begin
      snap_d = snap_q;
    end
    if (state_q == LAP) disp_d = snap_q;
    else                disp_d = live_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= {DIV_W{1'b0}};
      btn_start_q <= 1'b1;
      btn_lap_q   <= 1'b1;
      snap_q      <= 16'd0;
      disp_q      <= 16'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      btn_start_q <= btn_start;
      btn_lap_q   <= btn_lap;
      snap_q      <= snap_d;
      disp_q      <= disp_d;
      overflow_q  <= min_carry_s;
    end
  end

  bcd60_counter u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (time_clr_s),
    .en    (tick_s),
    .tens  (sec_tens_s),
    .ones  (sec_ones_s),
    .carry (sec_carry_s)
  );

  bcd60_counter u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (time_clr_s),
    .en    (sec_carry_s),
    .tens  (min_tens_s),
    .ones  (min_ones_s),
    .carry (min_carry_s)
  );

  assign state    = state_q;
  assign min_tens = disp_q[15:12];
  assign min_ones = disp_q[11:8];
  assign sec_tens = disp_q[7:4];
  assign sec_ones = disp_q[3:0];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (TICK_DIV=4): seconds-based reference model
// checked every cycle, plus hand-computed checkpoints.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic [1:0] state;
  logic       running;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int ovf_cnt = 0;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .state     (state),
    .running   (running),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: time and snapshot kept as plain seconds 0..3599.
  int m_state = 0, m_div = 0, m_time = 0, m_snap = 0, m_disp = 0;
  bit m_ovf = 1'b0, m_bs_q = 1'b1, m_bl_q = 1'b1, m_valid = 1'b0;

  always @(posedge clk) begin : model
    bit ps, pl, run, tk;
    if (rst) begin
      m_state = 0; m_div = 0; m_time = 0; m_snap = 0; m_disp = 0;
      m_ovf = 1'b0; m_bs_q = 1'b1; m_bl_q = 1'b1; m_valid = 1'b1;
    end else begin
      ps  = btn_start && !m_bs_q;
      pl  = btn_lap && !m_bl_q && !ps;
      run = (m_state == 2) || (m_state == 3);
      tk  = run && (m_div == TD - 1);
      m_disp = (m_state == 3) ? m_snap : m_time;
      m_ovf  = tk && (m_time == 3599);
      if (m_state == 1 && pl) begin
        m_time = 0; m_snap = 0; m_div = 0;
      end else begin
        if (m_state == 2 && pl) m_snap = m_time;
        if (tk) m_time = (m_time + 1) % 3600;
        if (run) m_div = tk ? 0 : m_div + 1;
      end
      case (m_state)
        0: if (ps) m_state = 2;
        2: if (ps) m_state = 1; else if (pl) m_state = 3;
        3: if (ps) m_state = 1; else if (pl) m_state = 2;
        1: if (ps) m_state = 2; else if (pl) m_state = 0;
        default: m_state = 0;
      endcase
      m_bs_q = btn_start;
      m_bl_q = btn_lap;
    end
  end

  function automatic logic [19:0] expect_vec(int st, int disp, bit ovf);
    int mm = disp / 60;
    int ss = disp % 60;
    return {2'(st), 1'(st >= 2), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), ovf};
  endfunction

  task automatic cmp_cycle();
    logic [19:0] got, exp;
    got = {state, running, min_tens, min_ones, sec_tens, sec_ones, overflow};
    exp = expect_vec(m_state, m_disp, m_ovf);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, got, exp);
    end
    if (overflow === 1'b1) ovf_cnt++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (m_valid) cmp_cycle();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_start = 1'b0; btn_lap = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic press_start();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
  endtask

  function automatic logic [15:0] disp16();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin : stim
    int ovf_base;
    // Reset with random button levels.
    for (int i = 0; i < 2; i++) begin
      btn_start = 1'($urandom_range(1, 0));
      btn_lap   = 1'($urandom_range(1, 0));
      cyc(1);
    end
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_disp", 32'(disp16()), 32'h0000);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0; btn_start = 1'b0; btn_lap = 1'b0;
    cyc(1);

    // Held start gives one transition; 60 ticks reach 01:00.
    btn_start = 1'b1;
    cyc(50);
    chk("held_start_state", 32'(state), 32'd2);
    btn_start = 1'b0;
    cyc(192);
    chk("one_minute_disp", 32'(disp16()), 32'h0100);

    // Lap at 00:05, frozen for 40 cycles, resume shows 00:15.
    do_reset();
    press_start();
    cyc(20);
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    chk("lap_state", 32'(state), 32'd3);
    chk("lap_disp", 32'(disp16()), 32'h0005);
    cyc(40);
    chk("lap_frozen_disp", 32'(disp16()), 32'h0005);
    chk("lap_frozen_state", 32'(state), 32'd3);
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    chk("resume_state", 32'(state), 32'd2);
    cyc(1);
    chk("resume_disp", 32'(disp16()), 32'h0015);

    // Simultaneous start and lap: start wins.
    btn_start = 1'b1; btn_lap = 1'b1;
    cyc(1);
    chk("both_state", 32'(state), 32'd1);
    btn_start = 1'b0; btn_lap = 1'b0;
    cyc(3);

    // Stop at 00:07, lap clears to IDLE.
    do_reset();
    press_start();
    cyc(28);
    press_start();
    cyc(1);
    chk("stop_state", 32'(state), 32'd1);
    chk("stop_disp", 32'(disp16()), 32'h0007);
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    chk("clear_state", 32'(state), 32'd0);
    cyc(1);
    chk("clear_disp", 32'(disp16()), 32'h0000);

    // Start held through reset release gives no pulse.
    rst = 1'b1; btn_start = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("held_rst_state", 32'(state), 32'd0);
    btn_start = 1'b0;
    cyc(1);

    // Reset mid-count clears everything on that edge.
    press_start();
    cyc(10);
    rst = 1'b1;
    cyc(1);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_disp", 32'(disp16()), 32'h0000);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);

    // Full hour wrap: one overflow pulse, back to 00:00.
    do_reset();
    press_start();
    ovf_base = ovf_cnt;
    cyc(14401);
    chk("wrap_disp", 32'(disp16()), 32'h0000);
    chk("wrap_state", 32'(state), 32'd2);
    chk("wrap_ovf_pulses", 32'(ovf_cnt - ovf_base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
